// File: rtl/approx_mul_final_cpa.sv
// Final carry-propagate adder of the 16-bit approximate multiplier: sums the
// compressor tree's sum/carry rows in two pipelined halves, optional LOA on the LSBs.
module approx_mul_final_cpa #(
  parameter int W        = 32,
  parameter int SPLIT    = 16,
  parameter int LOA_BITS = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] row_a,
  input  logic [W-1:0] row_b,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] prod,
  output logic         prod_ovf,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int EX = SPLIT - LOA_BITS;  // exact low bits in stage 1
  localparam int HI = W - SPLIT;

  logic               s1_valid, s2_valid;
  logic [SPLIT-1:0]   s1_lo;
  logic               s1_c;
  logic [HI-1:0]      s1_a_hi, s1_b_hi;

  logic [SPLIT-1:0]   lo_nxt;
  logic               c_nxt;
  logic               loa_c;
  logic [HI:0]        hi_sum;
  logic               s1_load, s2_adv;

  // Lower part: OR approximation, its carry seeds the exact section above it
  if (LOA_BITS > 0) begin : g_loa
    assign lo_nxt[LOA_BITS-1:0] = row_a[LOA_BITS-1:0] | row_b[LOA_BITS-1:0];
    assign loa_c = row_a[LOA_BITS-1] & row_b[LOA_BITS-1];
  end else begin : g_no_loa
    assign loa_c = 1'b0;
  end

  if (EX > 0) begin : g_exact
    logic [EX:0] ex_sum;
    assign ex_sum = {1'b0, row_a[SPLIT-1:LOA_BITS]} + {1'b0, row_b[SPLIT-1:LOA_BITS]}
                  + {{EX{1'b0}}, loa_c};
    assign lo_nxt[SPLIT-1:LOA_BITS] = ex_sum[EX-1:0];
    assign c_nxt = ex_sum[EX];
  end else begin : g_no_exact
    assign c_nxt = loa_c;
  end

  assign hi_sum = {1'b0, s1_a_hi} + {1'b0, s1_b_hi} + {{HI{1'b0}}, s1_c};

  assign s2_adv    = s1_valid & (~s2_valid | out_ready);
  assign in_ready  = ~rst & (~s1_valid | ~s2_valid | out_ready);
  assign s1_load   = in_valid & in_ready;
  assign out_valid = s2_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_c     <= 1'b0;
      s1_a_hi  <= '0;
      s1_b_hi  <= '0;
      s2_valid <= 1'b0;
      prod     <= '0;
      prod_ovf <= 1'b0;
    end else begin
      if (s2_adv) begin
        prod     <= {hi_sum[HI-1:0], s1_lo};
        prod_ovf <= hi_sum[HI];
        s2_valid <= 1'b1;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
      // A load in the same cycle as a drain keeps stage 1 occupied with new data
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_lo    <= lo_nxt;
        s1_c     <= c_nxt;
        s1_a_hi  <= row_a[W-1:SPLIT];
        s1_b_hi  <= row_b[W-1:SPLIT];
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_approx_mul_final_cpa.sv
// Bench for approx_mul_final_cpa: an exact instance and an LOA_BITS=4 instance
// share stimulus; results are checked against an arithmetic reference model.
module tb_approx_mul_final_cpa;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] row_a, row_b;
  logic        in_valid, out_ready;
  logic        in_ready, out_valid, prod_ovf;
  logic [31:0] prod;
  logic        l_in_ready, l_out_valid, l_prod_ovf;
  logic [31:0] l_prod;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  approx_mul_final_cpa #(.W(32), .SPLIT(16), .LOA_BITS(0)) u_dut (
    .clk(clk), .rst(rst), .row_a(row_a), .row_b(row_b), .in_valid(in_valid),
    .in_ready(in_ready), .prod(prod), .prod_ovf(prod_ovf), .out_valid(out_valid),
    .out_ready(out_ready));

  approx_mul_final_cpa #(.W(32), .SPLIT(16), .LOA_BITS(4)) u_loa (
    .clk(clk), .rst(rst), .row_a(row_a), .row_b(row_b), .in_valid(in_valid),
    .in_ready(l_in_ready), .prod(l_prod), .prod_ovf(l_prod_ovf), .out_valid(l_out_valid),
    .out_ready(out_ready));

  // {ovf, prod}: OR below loa, AND of the top OR'd bit pair as carry, true add above
  function automatic logic [32:0] model(logic [31:0] a, logic [31:0] b, int loa);
    logic [32:0] r;
    logic [31:0] mask;
    logic        c;
    if (loa == 0) return {1'b0, a} + {1'b0, b};
    mask = (32'h1 << loa) - 32'h1;
    c    = a[loa-1] & b[loa-1];
    r    = ({1'b0, a >> loa} + {1'b0, b >> loa} + {32'b0, c}) << loa;
    return r | {1'b0, (a | b) & mask};
  endfunction

  // Drive one beat with out_ready high; returns at the cycle its result is visible
  task automatic send_one(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    row_a = a; row_b = b; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; row_a = '0; row_b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || prod !== 32'h0 || prod_ovf !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ov=%b prod=%h ovf=%b ir=%b, want 0 0 0 0",
               out_valid, prod, prod_ovf, in_ready);
    end
    rst = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: ir=%b ov=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_exact();
    @(negedge clk);
    row_a = 32'h0000_FFFF; row_b = 32'h1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL exact_latency: out_valid=%b one cycle after accept, want 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || prod !== 32'h0001_0000 || prod_ovf !== 1'b0) begin
      errors++;
      $display("FAIL exact_split_carry: ov=%b prod=%h ovf=%b, want 1 00010000 0",
               out_valid, prod, prod_ovf);
    end
  endtask

  task automatic test_loa();
    send_one(32'hF, 32'h8);
    checks++;
    if (l_out_valid !== 1'b1 || l_prod !== 32'h1F || prod !== 32'h17) begin
      errors++;
      $display("FAIL loa_or_carry: loa prod=%h exact prod=%h, want 0000001f 00000017",
               l_prod, prod);
    end
    send_one(32'h3, 32'h5);
    checks++;
    if (l_out_valid !== 1'b1 || l_prod !== 32'h7 || l_prod_ovf !== 1'b0) begin
      errors++;
      $display("FAIL loa_or_only: prod=%h ovf=%b, want 00000007 0", l_prod, l_prod_ovf);
    end
  endtask

  task automatic test_overflow();
    send_one(32'hFFFF_FFFF, 32'h1);
    checks++;
    if (out_valid !== 1'b1 || prod !== 32'h0 || prod_ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow_wrap: ov=%b prod=%h ovf=%b, want 1 00000000 1",
               out_valid, prod, prod_ovf);
    end
    send_one(32'h1, 32'h1);
    checks++;
    if (out_valid !== 1'b1 || prod !== 32'h2 || prod_ovf !== 1'b0) begin
      errors++;
      $display("FAIL overflow_next: ov=%b prod=%h ovf=%b, want 1 00000002 0",
               out_valid, prod, prod_ovf);
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int got = 0;
    int first = -1;
    int last = -1;
    logic [32:0] exp;
    // Stall phase: 6 cycles with the consumer not ready
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        checks++;
        if (out_valid !== 1'b1 || prod !== 32'h1) begin
          errors++;
          $display("FAIL bp_hold c%0d: ov=%b prod=%h, want 1 00000001", c, out_valid, prod);
        end
      end
      row_a = (idx + 1) >> 1; row_b = (idx + 1) - ((idx + 1) >> 1);
      in_valid = 1'b1; out_ready = 1'b0; #1;
      if (in_ready) idx++;
    end
    checks++;
    if (idx != 2 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_capacity: accepted=%0d in_ready=%b, want 2 0", idx, in_ready);
    end
    // Release: in_ready must follow out_ready in the same cycle
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      if (idx < 4) begin
        row_a = (idx + 1) >> 1; row_b = (idx + 1) - ((idx + 1) >> 1); in_valid = 1'b1;
      end else in_valid = 1'b0;
      out_ready = 1'b1; #1;
      if (c == 0) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL bp_comb_ready: in_ready=%b, want 1", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        exp = model(got + 1 - ((got + 1) >> 1), (got + 1) >> 1, 0);
        checks++;
        if (prod !== exp[31:0]) begin
          errors++;
          $display("FAIL bp_order #%0d: prod=%h, want %h", got, prod, exp[31:0]);
        end
        if (first < 0) first = c;
        last = c;
        got++;
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 4 || last - first != 3) begin
      errors++;
      $display("FAIL bp_drain: got=%0d span=%0d, want 4 3", got, last - first);
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] qe[$];
    logic [32:0] ql[$];
    logic [32:0] e, l;
    logic [31:0] a, b;
    int sent = 0;
    int got = 0;
    int first = -1;
    int last = -1;
    @(negedge clk);
    for (int c = 0; c < 300 && got < 100; c++) begin
      if (c > 0) @(negedge clk);
      if (sent < 100) begin
        a = $urandom; b = $urandom;
        if (sent % 17 == 5) begin a = 32'hFFFF_FFFF; b = $urandom_range(1, 3); end
        row_a = a; row_b = b; in_valid = 1'b1;
      end else in_valid = 1'b0;
      out_ready = 1'b1; #1;
      if (out_valid && out_ready) begin
        checks++;
        if (qe.size() == 0 || ql.size() == 0) begin
          errors++;
          $display("FAIL b2b_spurious: output with nothing outstanding, prod=%h", prod);
        end else begin
          e = qe.pop_front(); l = ql.pop_front();
          if ({prod_ovf, prod} !== e || {l_prod_ovf, l_prod} !== l) begin
            errors++;
            $display("FAIL b2b #%0d: exact %b_%h want %b_%h, loa %b_%h want %b_%h", got,
                     prod_ovf, prod, e[32], e[31:0], l_prod_ovf, l_prod, l[32], l[31:0]);
          end
        end
        if (first < 0) first = c;
        last = c;
        got++;
      end
      if (in_valid && in_ready) begin
        qe.push_back(model(row_a, row_b, 0));
        ql.push_back(model(row_a, row_b, 4));
        sent++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != 100 || first != 2 || last - first != 99) begin
      errors++;
      $display("FAIL b2b_throughput: got=%0d first=%0d span=%0d, want 100 2 99",
               got, first, last - first);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; row_a = 32'hFFFF_FFFF; row_b = 32'h2;
    @(negedge clk);
    row_a = 32'h10; row_b = 32'h20;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || prod !== 32'h1 || prod_ovf !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_full: ov=%b prod=%h ovf=%b ir=%b, want 1 00000001 1 0",
               out_valid, prod, prod_ovf, in_ready);
    end
    rst = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ready: in_ready=%b during rst, want 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || prod !== 32'h0 || prod_ovf !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_clear: ov=%b prod=%h ovf=%b, want 0 0 0", out_valid, prod, prod_ovf);
    end
    rst = 1'b0; out_ready = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after: ir=%b ov=%b, want 1 0", in_ready, out_valid);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_ghost c%0d: out_valid=%b prod=%h, want 0", c, out_valid, prod);
      end
    end
    send_one(32'h1234, 32'h1);
    checks++;
    if (out_valid !== 1'b1 || prod !== 32'h1235 || prod_ovf !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_fresh: ov=%b prod=%h ovf=%b, want 1 00001235 0",
               out_valid, prod, prod_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_loa();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
